ex_div: RTL

Multi-cycle RV32M divider for the execute stage. It sits directly downstream of the ID/EX pipeline register and consumes its registered operands (`op1`, `op2`) and destination register. It runs DIV/DIVU/REM/REMU with a radix-2 restoring algorithm. While it works it holds the pipeline through the control block, and it returns a one-cycle result strobe that the EX write-back mux consumes.

---
 rtl/ex_div_pkg.sv | 23 ++
 rtl/ex_div.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ex_div_pkg.sv
// Shared constants and state type for the RV32M execute-stage divider.
package ex_div_pkg;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [4:0]  ZERO_REG  = 5'd0;

   localparam logic [2:0] INST_DIV  = 3'b100;
   localparam logic [2:0] INST_DIVU = 3'b101;
   localparam logic [2:0] INST_REM  = 3'b110;
   localparam logic [2:0] INST_REMU = 3'b111;

   localparam logic [31:0] INT_MIN   = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;
   localparam logic [4:0]  LAST_ITER = 5'd31;

   typedef enum logic [1:0] {
      DIV_IDLE  = 2'd0,
      DIV_START = 2'd1,
      DIV_CALC  = 2'd2,
      DIV_END   = 2'd3
   } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// DIV_IDLE  | waiting for a divide op; operands latched on accept
// DIV_START | special cases resolved, otherwise operands made positive
// DIV_CALC  | 32 shift/trial-subtract iterations
// DIV_END   | signed result and strobe presented for one cycle
module ex_div
   import ex_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic        jump_ctrl_i,
   output logic [31:0] result_o,
   output logic        ready_o,
   output logic        busy_o,
   output logic [4:0]  reg_waddr_o
);

   div_state_e  state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dsr_q, dsr_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        neg_quot_q, neg_quot_d;
   logic        neg_rem_q, neg_rem_d;
   logic        ready_q, ready_d;

   logic        is_signed;
   logic [32:0] trial;

   // op[0] clear means DIV/REM; op[1] set selects the remainder
   assign is_signed = ~op_q[0];
   // dvd_q doubles as the quotient shift register during CALC
   assign trial     = {rem_q, dvd_q[31]} - {1'b0, dsr_q};

   // Next-state and datapath; the signed result is formed on the edge into
   // DIV_END so result_o/ready_o come straight from flops.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dvd_d      = dvd_q;
      dsr_d      = dsr_q;
      rem_d      = rem_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      waddr_d    = waddr_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      ready_d    = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (start_i && op_i[2]) begin
               op_d    = op_i[1:0];
               dvd_d   = dividend_i;
               dsr_d   = divisor_i;
               waddr_d = reg_waddr_i;
               state_d = DIV_START;
            end
         end
         DIV_START: begin
            if (jump_ctrl_i) begin
               state_d = DIV_IDLE;
            end else if (dsr_q == ZERO_WORD) begin
               result_d = op_q[1] ? dvd_q : ALL_ONES;
               ready_d  = 1'b1;
               state_d  = DIV_END;
            end else if (is_signed && dvd_q == INT_MIN && dsr_q == ALL_ONES) begin
               result_d = op_q[1] ? ZERO_WORD : INT_MIN;
               ready_d  = 1'b1;
               state_d  = DIV_END;
            end else begin
               neg_quot_d = is_signed & (dvd_q[31] ^ dsr_q[31]);
               neg_rem_d  = is_signed & dvd_q[31];
               dvd_d      = (is_signed && dvd_q[31]) ? -dvd_q : dvd_q;
               dsr_d      = (is_signed && dsr_q[31]) ? -dsr_q : dsr_q;
               rem_d      = ZERO_WORD;
               cnt_d      = LAST_ITER;
               state_d    = DIV_CALC;
            end
         end
         DIV_CALC: begin
            if (jump_ctrl_i) begin
               state_d = DIV_IDLE;
            end else begin
               dvd_d = {dvd_q[30:0], ~trial[32]};
               rem_d = trial[32] ? {rem_q[30:0], dvd_q[31]} : trial[31:0];
               if (cnt_q == 5'd0) begin
                  if (op_q[1]) begin
                     result_d = neg_rem_q ? -rem_d : rem_d;
                  end else begin
                     result_d = neg_quot_q ? -dvd_d : dvd_d;
                  end
                  ready_d = 1'b1;
                  state_d = DIV_END;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
         end
         DIV_END: begin
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared by the async active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= DIV_IDLE;
         op_q       <= 2'b00;
         dvd_q      <= ZERO_WORD;
         dsr_q      <= ZERO_WORD;
         rem_q      <= ZERO_WORD;
         result_q   <= ZERO_WORD;
         cnt_q      <= 5'd0;
         waddr_q    <= ZERO_REG;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dvd_q      <= dvd_d;
         dsr_q      <= dsr_d;
         rem_q      <= rem_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
         waddr_q    <= waddr_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         ready_q    <= ready_d;
      end
   end

   // Hold must already be asserted in the issue cycle, and drops in END so
   // the pipeline advances while the result is written back.
   assign busy_o = (state_q == DIV_IDLE && start_i && op_i[2]) ||
                   (state_q == DIV_START) || (state_q == DIV_CALC);

   assign result_o    = result_q;
   assign ready_o     = ready_q;
   assign reg_waddr_o = waddr_q;

endmodule
